// File: rtl/bram_seq_master_if.sv
// rtl/bram_seq_master_if.sv - request and response channels of bram_seq_master
// slave: the sequencer's view; master: the requester/consumer's view.
interface bram_seq_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [7:0]  rsp_addr;
  logic        rsp_last;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
  );
endinterface

// File: rtl/bram_seq_master.sv
// rtl/bram_seq_master.sv - request/sweep sequencer for one SB_RAM256x16 with credit-managed response FIFO
// Optional full-RAM sweep engine is built when BRAM_SEQ_SWEEP_EN is defined.
module bram_seq_master #(
  parameter int RSP_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bram_seq_master_if.slave       bus,
  input  logic                   sweep_start,
  input  logic [7:0]             sweep_base,
  output logic                   sweep_busy,
  output logic                   ram_we,
  output logic                   ram_wclke,
  output logic                   ram_re,
  output logic                   ram_rclke,
  output logic [7:0]             ram_waddr,
  output logic [7:0]             ram_raddr,
  output logic [15:0]            ram_wdata,
  output logic [15:0]            ram_mask,
  input  logic [15:0]            ram_rdata
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
`ifdef BRAM_SEQ_SWEEP_EN
  localparam int ENT_W = 25;
`else
  localparam int ENT_W = 24;
`endif
  localparam logic [CW:0] DEPTH_L = (CW+1)'(RSP_DEPTH);

  logic        idle;
  logic        swp_issue;
  logic [7:0]  swp_addr;
  logic        swp_last;
  logic [1:0]  in_flight;
  logic        credit_ok;
  logic        req_fire;
  logic        push;
  logic        pop;

  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_waddr_q, ram_waddr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;
  logic        ram_re_q, ram_re_d;
  logic [7:0]  ram_raddr_q, ram_raddr_d;
  logic        rlast1_q, rlast1_d;
  logic        rd_vld_q, rd_vld_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic        rd_last_q, rd_last_d;

  logic [ENT_W-1:0] mem_q [RSP_DEPTH];
  logic [ENT_W-1:0] mem_d [RSP_DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ENT_W-1:0] push_ent;
  logic [ENT_W-1:0] head;

  // in_flight = read on the RAM port this cycle + read whose data is on ram_rdata now
  assign in_flight = {1'b0, ram_re_q} + {1'b0, rd_vld_q};
  assign credit_ok = ({1'b0, count_q} + {{(CW-1){1'b0}}, in_flight}) < DEPTH_L;

  assign bus.req_ready = ~rst & idle & (bus.req_we | credit_ok);
  assign req_fire      = bus.req_valid & bus.req_ready;
  assign push          = rd_vld_q;
  assign pop           = (count_q != '0) & bus.rsp_ready;

`ifdef BRAM_SEQ_SWEEP_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       pend_q, pend_d;
  logic [7:0] saddr_q, saddr_d;
  logic [7:0] scnt_q, scnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      saddr_q <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      saddr_q <= saddr_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    saddr_d   = saddr_q;
    scnt_d    = scnt_q;
    swp_issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sweep_start) saddr_d = sweep_base;
        if (sweep_start || pend_q) begin
          scnt_d = '0;
          if (in_flight == 2'd0) begin
            state_d = S_SWEEP;
            pend_d  = 1'b0;
          end else begin
            pend_d  = 1'b1;
          end
        end
      end
      S_SWEEP: begin
        if (credit_ok) begin
          swp_issue = 1'b1;
          saddr_d   = saddr_q + 8'd1;
          scnt_d    = scnt_q + 8'd1;
          if (scnt_q == 8'hFF) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_vld_q && rd_last_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign idle       = (state_q == S_IDLE);
  assign sweep_busy = ~idle;
  assign swp_addr   = saddr_q;
  assign swp_last   = (scnt_q == 8'hFF);
  assign push_ent   = {ram_rdata, rd_addr_q, rd_last_q};
`else
  logic unused_sweep;
  assign unused_sweep = &{1'b0, sweep_start, sweep_base, rd_last_q};
  assign idle       = 1'b1;
  assign sweep_busy = 1'b0;
  assign swp_issue  = 1'b0;
  assign swp_addr   = '0;
  assign swp_last   = 1'b0;
  assign push_ent   = {ram_rdata, rd_addr_q};
`endif

  always_comb begin
    ram_we_d    = req_fire & bus.req_we;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    if (ram_we_d) begin
      ram_waddr_d = bus.req_addr;
      ram_wdata_d = bus.req_wdata;
    end
    ram_re_d    = (req_fire & ~bus.req_we) | swp_issue;
    ram_raddr_d = ram_raddr_q;
    if (swp_issue)     ram_raddr_d = swp_addr;
    else if (ram_re_d) ram_raddr_d = bus.req_addr;
    rlast1_d  = swp_issue & swp_last;
    rd_vld_d  = ram_re_q;
    rd_addr_d = ram_raddr_q;
    rd_last_d = rlast1_q;
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = push_ent;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      ram_re_q    <= 1'b0;
      ram_raddr_q <= '0;
      rlast1_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_last_q   <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_re_q    <= ram_re_d;
      ram_raddr_q <= ram_raddr_d;
      rlast1_q    <= rlast1_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      rd_last_q   <= rd_last_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: an empty count masks stale entries.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head          = mem_q[rptr_q];
  assign bus.rsp_valid = (count_q != '0);
  assign bus.rsp_data  = bus.rsp_valid ? head[ENT_W-1 -: 16] : 16'h0;
  assign bus.rsp_addr  = bus.rsp_valid ? head[ENT_W-17 -: 8] : 8'h0;
`ifdef BRAM_SEQ_SWEEP_EN
  assign bus.rsp_last  = bus.rsp_valid & head[0];
`else
  assign bus.rsp_last  = 1'b0;
`endif

  assign ram_we    = ram_we_q;
  assign ram_wclke = ram_we_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_re    = ram_re_q;
  assign ram_rclke = ram_re_q;
  assign ram_raddr = ram_raddr_q;
  assign ram_mask  = 16'h0;
endmodule

// File: doc/bram_seq_master.md
# bram_seq_master

Initiator-side sequencer for one SB_RAM256x16 block RAM. It accepts single-word read/write requests on a valid/ready handshake and drives the RAM's write and read ports. It also captures the registered read data into a response FIFO that honours downstream backpressure. An optional sweep engine streams all 256 words, such as a stored waveform table, without per-word requests; this gives the netlist simulator tests a stimulus source that exercises BRAM ports as a real master would.

## Interface
Parameters:
- RSP_DEPTH, 4: response FIFO depth; power of two, ≥ 4.

Ports:
- clk  in  1  single clock; drives the RAM's WCLK and RCLK externally.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid & ready at the rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  8  word address.
- req_wdata  in  16  write data; ignored for reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  response consumed when valid & ready.
- rsp_data  out  16  read word.
- rsp_addr  out  8  address of the read word.
- rsp_last  out  1  final word of a sweep.
- sweep_start  in  1  one-cycle pulse that starts a sweep.
- sweep_base  in  8  first sweep address, sampled at start.
- sweep_busy  out  1  sweep in progress.
- ram_we, ram_wclke  out  1  write enable and write clock enable; both equal 1 in the cycle a write is issued.
- ram_re, ram_rclke  out  1  read enable and read clock enable; both equal 1 in the cycle a read is issued.
- ram_waddr, ram_raddr  out  8  RAM addresses.
- ram_wdata  out  16  RAM write data.
- ram_mask  out  16  constant 0, so all bits are written.
- ram_rdata  in  16  RAM RDATA, valid the cycle after a read issue.

## Operation
- Every RAM-side output is registered.
  - A request accepted at the edge ending cycle N is issued to the RAM in cycle N+1.
  - For a read, ram_rdata is valid in cycle N+2 and is pushed into the FIFO at the end of N+2.
- Credit rule for reads:
  - Reads are accepted only while fifo_count + in_flight < RSP_DEPTH.
  - in_flight counts reads issued whose data has not yet been pushed, 0..2.
  - The FIFO therefore never overflows, and ram_rdata is never dropped.
- Writes are accepted whenever the FSM is IDLE; they need no credit.
- req_ready = (state == IDLE) & (req_we ? 1 : credit_ok).
- Ordering: requests are issued in acceptance order, one per cycle. A read accepted immediately after a write to the same address returns the new data.
- FSM states:
  - IDLE → SWEEP on sweep_start when in_flight == 0. If sweep_start arrives with in_flight ≠ 0, the start is held pending until in_flight == 0.
  - In SWEEP, one read is issued per cycle while credit_ok holds; the address starts at sweep_base and increments mod 256, so 0xFF wraps to 0x00.
  - SWEEP → DRAIN after the 256th issue.
  - DRAIN → IDLE when that read has been pushed.
- sweep_busy = 1 in SWEEP and DRAIN. req_ready = 0 in SWEEP and DRAIN.
- sweep_start while sweep_busy is ignored.
- rsp_last = 1 only on the response entry from the 256th sweep read. The flag travels in the FIFO with its entry.
- FIFO: RSP_DEPTH entries of {data, addr, last}. A push and a pop in the same cycle are both allowed; the count is unchanged.
- rsp_* outputs are the FIFO head; rsp_valid = (count ≠ 0).

## Timing
- Reset values: all outputs 0, ram_mask 0, FSM in IDLE, FIFO empty, in_flight 0, pending start cleared.
- req_ready goes to 1 in the first cycle after rst deasserts.
- Reset mid-operation: in-flight reads are discarded and the FIFO is flushed. No rsp_valid appears after reset from pre-reset reads, and the sweep is aborted.
- Read latency is acceptance to rsp_valid = 3 cycles when the FIFO is empty and rsp_ready = 1.
- Throughput is 1 read/cycle sustained when rsp_ready = 1 continuously.
- Full backpressure (rsp_ready = 0): exactly RSP_DEPTH reads are accepted, then req_ready drops to 0 until a pop.
- Writes stay acceptable under full backpressure, because writes need no credit.
- Sweep timing with rsp_ready = 1: rsp_last arrives 258 cycles after the first sweep issue cycle.

## Configuration
- BRAM_SEQ_SWEEP_EN defined:
  - The sweep engine and the SWEEP/DRAIN states are built.
  - rsp_last is carried in the FIFO.
- Undefined:
  - The FSM is IDLE only, and sweep_start and sweep_base are ignored.
  - sweep_busy and rsp_last are tied 0.
  - The FIFO width is 24 bits.

## Test plan
- Write 0x1234 to addr 0x10, then read 0x10 in the next cycle. Required: ram_we and ram_wclke are 1 for one cycle with ram_waddr = 0x10; rsp_data = 0x1234 and rsp_addr = 0x10 arrive 3 cycles after the read is accepted.
- Preload the RAM model with INIT addr n = n*3 and hold rsp_ready = 0. Issue 6 reads. Required: exactly 4 are accepted. Raise rsp_ready: responses 0..3 come out in order, then the remaining 2 are accepted.
- Sweep with sweep_base = 0xFE and rsp_ready = 1. Required: rsp_addr sequence 0xFE, 0xFF, 0x00 … 0xFD, 256 responses, rsp_last only on 0xFD, sweep_busy falls the cycle after the last push.
- Sweep with rsp_ready toggling at 50% duty. Required: no response lost or duplicated, and the FIFO count never exceeds 4.
- Assert rst for 1 cycle while 2 reads are in flight and 3 entries are buffered. Required: all outputs 0 the following cycle, and no rsp_valid until new reads are issued.
- Undefined BRAM_SEQ_SWEEP_EN, pulse sweep_start. Required: sweep_busy stays 0, no ram_re, and req_ready stays 1.
